// File: rtl/rx_buffer_pkg.sv
// Shared types and constants for the UART receive-side word buffer.
package rx_buffer_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int NUM_DEFAULT    = 9;

  typedef logic [31:0] word_t;
  typedef logic [7:0]  byte_t;

endpackage

// File: rtl/word_fifo.sv
// Synchronous word FIFO of 2**NUM entries; a pop in the same cycle frees the
// slot for a push arriving while full.
module word_fifo
  import rx_buffer_pkg::*;
#(
  parameter int NUM = NUM_DEFAULT
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         push,
  input  word_t        push_data,
  input  logic         pop,
  output word_t        head_data,
  output logic         pop_ok,
  output logic [NUM:0] count,
  output logic         full,
  output logic         empty
);

  localparam logic [NUM:0]   DEPTH_C   = {1'b1, {NUM{1'b0}}};
  localparam logic [NUM:0]   CNT_ONE_C = {{NUM{1'b0}}, 1'b1};
  localparam logic [NUM-1:0] PTR_ONE_C = {{(NUM-1){1'b0}}, 1'b1};

  word_t          mem_r [0:(2**NUM)-1];
  logic [NUM-1:0] head_r;
  logic [NUM-1:0] tail_r;
  logic [NUM:0]   count_r;
  logic [NUM:0]   count_nxt_s;
  logic           full_r;
  logic           empty_r;
  logic           pop_ok_s;
  logic           push_ok_s;

  // Qualify requests against pre-edge occupancy and compute next count.
  always_comb begin
    pop_ok_s  = pop & ~empty_r;
    push_ok_s = push & (~full_r | pop_ok_s);
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE_C;
      2'b01:   count_nxt_s = count_r - CNT_ONE_C;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers and registered status flags.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      head_r  <= {NUM{1'b0}};
      tail_r  <= {NUM{1'b0}};
      count_r <= {(NUM+1){1'b0}};
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      if (push_ok_s) begin
        tail_r <= tail_r + PTR_ONE_C;
      end
      if (pop_ok_s) begin
        head_r <= head_r + PTR_ONE_C;
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == DEPTH_C);
      empty_r <= (count_nxt_s == {(NUM+1){1'b0}});
    end
  end

  // Storage is left unreset so it can map onto plain RAM.
  always_ff @(posedge CLK) begin
    if (push_ok_s) begin
      mem_r[tail_r] <= push_data;
    end
  end

  assign head_data = mem_r[head_r];
  assign pop_ok    = pop_ok_s;
  assign count     = count_r;
  assign full      = full_r;
  assign empty     = empty_r;

endmodule

// File: rtl/receiver_buffer.sv
// Packs received UART bytes MSB-first into 32-bit words, queues them and
// hands them to the CPU with a one-cycle read latency.
module receiver_buffer
  import rx_buffer_pkg::*;
#(
  parameter int NUM = NUM_DEFAULT
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         read,
  output logic [31:0]  out_data,
  output logic         out_valid,
  output logic         empty,
  output logic [NUM:0] count,
  output logic         overflow
);

  localparam logic [1:0] LAST_IDX_C = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  byte_idx_r;
  logic [23:0] partial_r;
  logic        push_s;
  word_t       push_word_s;
  word_t       head_data_s;
  logic        pop_ok_s;
  logic        full_s;
  word_t       out_data_r;
  logic        out_valid_r;
  logic        overflow_r;

  // The last byte bypasses the partial register and completes the word directly.
  always_comb begin
    push_s      = in_valid & (byte_idx_r == LAST_IDX_C);
    push_word_s = {partial_r, in_data};
  end

  // Byte assembler.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      byte_idx_r <= 2'd0;
      partial_r  <= 24'd0;
    end else if (in_valid) begin
      case (byte_idx_r)
        2'd0:    partial_r[23:16] <= in_data;
        2'd1:    partial_r[15:8]  <= in_data;
        2'd2:    partial_r[7:0]   <= in_data;
        default: partial_r        <= partial_r;
      endcase
      byte_idx_r <= byte_idx_r + 2'd1;
    end
  end

  word_fifo #(
    .NUM(NUM)
  ) u_word_fifo (
    .CLK      (CLK),
    .reset    (reset),
    .push     (push_s),
    .push_data(push_word_s),
    .pop      (read),
    .head_data(head_data_s),
    .pop_ok   (pop_ok_s),
    .count    (count),
    .full     (full_s),
    .empty    (empty)
  );

  // Read-data register and sticky overflow; a word is lost only when full with no pop.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      out_data_r  <= 32'd0;
      out_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      out_valid_r <= pop_ok_s;
      if (pop_ok_s) begin
        out_data_r <= head_data_s;
      end
      overflow_r <= overflow_r | (push_s & full_s & ~pop_ok_s);
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign overflow  = overflow_r;

endmodule

// File: doc/receiver_buffer.md
Name: receiver_buffer

Overview:
Receive-side companion to the UART transmit buffer. Accepts single bytes from the UART receiver and packs each group of four into one 32-bit word, most significant byte first. Stores completed words in a FIFO of 2**NUM entries and hands them to the CPU core through a one-cycle-latency read handshake. Reports empty status, occupancy and a sticky overflow flag.

Parameters:
NUM, 9, log2 of FIFO depth (depth = 2**NUM words)

Ports:
CLK  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
in_data  input  8  received byte from UART receiver
in_valid  input  1  one-cycle strobe, in_data valid this cycle
read  input  1  CPU pop request, level; one pop per cycle while high and not empty
out_data  output  32  popped word, valid when out_valid=1
out_valid  output  1  one-cycle strobe, out_data holds the popped word
empty  output  1  FIFO holds zero complete words
count  output  NUM+1  number of complete words stored (0..2**NUM)
overflow  output  1  sticky; a completed word was dropped because the FIFO was full

Behaviour:
- Reset (asynchronous, active-high): out_data=0, out_valid=0, empty=1, count=0, overflow=0, byte index=0, head=tail=0, partial word cleared. Storage contents are don't-care.
- Assembler:
  - 2-bit byte index, 0..3.
  - On in_valid, in_data goes to bits [31:24], [23:16], [15:8], [7:0] for index 0, 1, 2, 3 respectively, then the index increments.
  - On the in_valid with index=3, the completed word {b0,b1,b2,b3} is pushed in that same cycle. The index wraps to 0.
  - in_valid=0 leaves the assembler unchanged. No timeout: a partial word waits indefinitely.
- Push:
  - Write at tail; tail <= tail+1, wrapping mod 2**NUM.
  - If count==2**NUM and no pop occurs in the same cycle, the word is dropped, overflow <= 1 and tail is unchanged.
- Pop:
  - Occurs when read=1 and count!=0, evaluated on pre-edge count.
  - out_data <= mem[head]; head <= head+1 (wrapping); out_valid <= 1 next cycle.
  - out_valid is 0 on every cycle without a pop. out_data holds its last value.
  - read=1 while empty: ignored, no error. The CPU keeps read high until out_valid.
- Simultaneous push and pop:
  - Both occur and count is unchanged.
  - When full, the pop frees the slot, so the push is accepted with no overflow.
  - When empty, only the push occurs; the pop is not satisfied that cycle.
- Latency: a word becomes visible (count/empty updated) the cycle after its 4th byte strobe. Earliest out_valid is 2 cycles after the 4th byte strobe.
- count, empty and overflow are registered outputs. empty == (count==0).
- Reset mid-assembly or with words queued: all are discarded, and the first byte after reset is taken as byte 0.

Decomposition:
- Package rx_buffer_pkg holds:
  - BYTES_PER_WORD=4
  - typedef word_t (logic [31:0])
  - typedef byte_t (logic [7:0])
  - default NUM
- One sub-module, word_fifo: parameterised synchronous FIFO (NUM, 32-bit) with push/pop/count/full/empty and simultaneous push+pop-at-full support.
- receiver_buffer contains the assembler, the overflow flag and the out_valid/out_data register.

Test Plan:
- Bytes 0x12,0x34,0x56,0x78 on consecutive in_valid, read held high -> empty=0 one cycle after 4th byte; next cycle out_valid=1, out_data=0x12345678; count returns to 0, empty=1.
- Bytes spaced by idle cycles (in_valid gaps of 0-5 cycles) for 0xDE,0xAD,0xBE,0xEF -> single word 0xDEADBEEF; no push before the 4th byte.
- 512 words pushed, read=0 -> count=512; a 513th word -> overflow=1, count=512; popping all returns words 0..511 in order, and the 513th word never appears.
- FIFO full and 4th byte strobe in the same cycle as read=1 -> overflow stays 0, count stays 512, and the new word appears last in the drain order.
- read held high on an empty FIFO for 10 cycles, then 4 bytes arrive -> out_valid stays 0 until 2 cycles after the 4th byte, then pulses once with the correct word.
- 2 bytes sent, reset pulsed mid-cycle (asynchronous), then 0x01,0x02,0x03,0x04 -> out_data=0x01020304; 1000 words streamed with random reads -> order preserved across pointer wrap and count never exceeds 512.
